// File: rtl/cordic_quad_wrap_if.sv
// rtl/cordic_quad_wrap_if.sv - angle-in, core, and result-out signal bundle for cordic_quad_wrap
interface cordic_quad_wrap_if #(
    parameter int BIT_WIDTH = 16
);
    logic                 in_valid;
    logic                 in_ready;
    logic [BIT_WIDTH-1:0] in_angle;
    logic                 core_start;
    logic [BIT_WIDTH-1:0] core_target;
    logic                 core_done;
    logic [BIT_WIDTH-1:0] core_x;
    logic [BIT_WIDTH-1:0] core_y;
    logic                 out_valid;
    logic                 out_ready;
    logic [BIT_WIDTH-1:0] out_cos;
    logic [BIT_WIDTH-1:0] out_sin;
    logic                 out_timeout;

    modport slave (
        input  in_valid, in_angle, core_done, core_x, core_y, out_ready,
        output in_ready, core_start, core_target, out_valid, out_cos, out_sin, out_timeout
    );

    modport master (
        output in_valid, in_angle, core_done, core_x, core_y, out_ready,
        input  in_ready, core_start, core_target, out_valid, out_cos, out_sin, out_timeout
    );
endinterface

// File: rtl/cordic_quad_wrap.sv
// rtl/cordic_quad_wrap.sv - quadrant reduction and correction wrapper around an iterative CORDIC core
module cordic_quad_wrap #(
    parameter int BIT_WIDTH = 16,
    parameter int TIMEOUT   = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    cordic_quad_wrap_if.slave bus
);
    localparam int TO_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_OUT
    } state_t;

    state_t               r_state;
    state_t               w_next;
    logic [1:0]           r_quad;
    logic [BIT_WIDTH-1:0] r_target;
    logic [BIT_WIDTH-1:0] r_cos;
    logic [BIT_WIDTH-1:0] r_sin;
    logic                 r_timeout;
    logic [TO_W-1:0]      r_cnt;

    logic                 w_accept;
    logic                 w_expired;
    logic                 w_capture;
    logic [BIT_WIDTH-1:0] w_neg_x;
    logic [BIT_WIDTH-1:0] w_neg_y;
    logic [BIT_WIDTH-1:0] w_cos;
    logic [BIT_WIDTH-1:0] w_sin;

    assign w_accept  = bus.in_valid && (r_state == S_IDLE);
    assign w_expired = (r_cnt == TO_W'(TIMEOUT - 1));
    assign w_capture = (r_state == S_WAIT) && (bus.core_done || w_expired);
    assign w_neg_x   = '0 - bus.core_x;
    assign w_neg_y   = '0 - bus.core_y;

    // Rotate the first-quadrant core result back by q * 90 degrees.
    always_comb begin
        w_cos = bus.core_x;
        w_sin = bus.core_y;
        case (r_quad)
            2'd1: begin
                w_cos = w_neg_y;
                w_sin = bus.core_x;
            end
            2'd2: begin
                w_cos = w_neg_x;
                w_sin = w_neg_y;
            end
            2'd3: begin
                w_cos = bus.core_y;
                w_sin = w_neg_x;
            end
            default: begin
                w_cos = bus.core_x;
                w_sin = bus.core_y;
            end
        endcase
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_next = S_ISSUE;
            S_ISSUE: w_next = S_WAIT;
            S_WAIT:  if (w_capture) w_next = S_OUT;
            S_OUT:   if (bus.out_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_quad    <= '0;
            r_target  <= '0;
            r_cos     <= '0;
            r_sin     <= '0;
            r_timeout <= 1'b0;
            r_cnt     <= '0;
        end else begin
            if (w_accept) begin
                r_quad   <= bus.in_angle[BIT_WIDTH-1:BIT_WIDTH-2];
                r_target <= {1'b0, bus.in_angle[BIT_WIDTH-3:0], 1'b0};
            end
            if (r_state == S_ISSUE) begin
                r_cnt <= '0;
            end else if (r_state == S_WAIT) begin
                r_cnt <= r_cnt + TO_W'(1);
            end
            // core_done wins over an expiry on the same edge.
            if (w_capture) begin
                r_cos     <= w_cos;
                r_sin     <= w_sin;
                r_timeout <= ~bus.core_done;
            end
        end
    end

    assign bus.in_ready    = (r_state == S_IDLE);
    assign bus.core_start  = (r_state == S_ISSUE);
    assign bus.core_target = r_target;
    assign bus.out_valid   = (r_state == S_OUT);
    assign bus.out_cos     = r_cos;
    assign bus.out_sin     = r_sin;
    assign bus.out_timeout = r_timeout;
endmodule

// File: tb/tb_cordic_quad_wrap.sv
// tb/tb_cordic_quad_wrap.sv - scoreboard bench for cordic_quad_wrap with a behavioural core model
module tb_cordic_quad_wrap;
    localparam int BW      = 16;
    localparam int TIMEOUT = 64;

    typedef struct {
        logic [BW-1:0] c;
        logic [BW-1:0] s;
        logic          t;
    } exp_t;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;
    exp_t exp_q[$];

    cordic_quad_wrap_if #(.BIT_WIDTH(BW)) bus ();

    cordic_quad_wrap #(.BIT_WIDTH(BW), .TIMEOUT(TIMEOUT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: remainder within the quadrant doubled, result rotated by q quarter turns.
    function automatic void ref_model(input logic [BW-1:0] a, input logic [BW-1:0] x,
                                      input logic [BW-1:0] y, output logic [BW-1:0] c,
                                      output logic [BW-1:0] s, output logic [BW-1:0] tgt);
        int            q;
        logic [BW-1:0] tmp;
        q   = int'(a) / (1 << (BW - 2));
        tgt = BW'((int'(a) % (1 << (BW - 2))) * 2);
        c   = x;
        s   = y;
        for (int i = 0; i < q; i++) begin
            tmp = c;
            c   = -s;
            s   = tmp;
        end
    endfunction

    // Monitor: compares on each output handshake and checks hold while stalled.
    logic [BW-1:0] prev_c, prev_s;
    logic          prev_t;
    bit            have_prev;
    initial have_prev = 0;
    always @(negedge clk) begin
        exp_t e;
        if (rst_n === 1'b1) begin
            if (bus.out_valid === 1'b1) begin
                check("in_ready_low_in_out", bus.in_ready, 0);
                if (have_prev) begin
                    check("hold_cos", bus.out_cos, prev_c);
                    check("hold_sin", bus.out_sin, prev_s);
                    check("hold_timeout", bus.out_timeout, prev_t);
                end
                prev_c    = bus.out_cos;
                prev_s    = bus.out_sin;
                prev_t    = bus.out_timeout;
                have_prev = 1;
                if (bus.out_ready === 1'b1) begin
                    if (exp_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL unexpected_output: got cos 0x%0h with no pending operation", bus.out_cos);
                    end else begin
                        e = exp_q.pop_front();
                        check("out_cos", bus.out_cos, e.c);
                        check("out_sin", bus.out_sin, e.s);
                        check("out_timeout", bus.out_timeout, e.t);
                    end
                    have_prev = 0;
                end
            end else begin
                have_prev = 0;
            end
        end else begin
            have_prev = 0;
        end
    end

    task automatic do_accept(input logic [BW-1:0] a, output bit ok);
        int n;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b1;
        bus.in_angle = a;
        n = 0;
        ok = 0;
        while (!ok && n < 200) begin
            @(negedge clk);
            n++;
            if (bus.in_ready === 1'b1) ok = 1;
        end
        if (!ok) begin
            n_tests++;
            n_fail++;
            $display("FAIL accept_timeout: in_ready never rose within 200 cycles");
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_angle = BW'($urandom);
    endtask

    // k: WAIT cycle (1-based) on which core_done is presented, 0 = never.
    task automatic run_op(input logic [BW-1:0] a, input logic [BW-1:0] x, input logic [BW-1:0] y,
                          input int k, input bit stale, input int stall);
        exp_t          e;
        logic [BW-1:0] tgt;
        int            n;
        int            exp_lat;
        bit            seen;
        bit            ok;
        ref_model(a, x, y, e.c, e.s, tgt);
        e.t = (k == 0 || k > TIMEOUT);
        exp_lat = e.t ? TIMEOUT + 2 : k + 2;
        exp_q.push_back(e);
        bus.core_x = x;
        bus.core_y = y;
        do_accept(a, ok);
        n = 0;
        seen = 0;
        while (!seen && n < 200) begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                check("core_start", bus.core_start, 1);
                check("core_target", bus.core_target, tgt);
            end
            if (n == 2) check("start_one_cycle", bus.core_start, 0);
            if (bus.out_valid === 1'b1) begin
                seen = 1;
            end else begin
                bus.core_done = (k != 0 && n == k + 1) || (stale && n == 1);
                if (n >= 2) begin
                    bus.in_valid = 1'($urandom);
                    bus.in_angle = BW'($urandom);
                end
            end
        end
        bus.core_done = 1'b0;
        bus.in_valid  = 1'b0;
        bus.core_x    = BW'($urandom);
        bus.core_y    = BW'($urandom);
        check("latency", n, exp_lat);
        if (!seen) begin
            exp_q.delete();
            return;
        end
        bus.in_valid = (stall > 0);
        repeat (stall) @(negedge clk);
        @(posedge clk);
        #1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        @(negedge clk);
        check("idle_after_handshake", bus.in_ready, 1);
        check("out_valid_dropped", bus.out_valid, 0);
    endtask

    task automatic reset_mid_op(input logic [BW-1:0] a);
        bit ok;
        int hits;
        do_accept(a, ok);
        repeat (5) @(negedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_core_target", bus.core_target, 0);
        hits = 0;
        repeat (80) begin
            @(negedge clk);
            if (bus.out_valid === 1'b1) hits++;
        end
        check("no_output_after_abort", hits, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [BW-1:0] a;
        n_tests       = 0;
        n_fail        = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_angle  = '0;
        bus.core_done = 1'b0;
        bus.core_x    = '0;
        bus.core_y    = '0;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_in_ready", bus.in_ready, 1);
        check("reset_out_valid", bus.out_valid, 0);
        check("reset_core_start", bus.core_start, 0);
        check("reset_core_target", bus.core_target, 0);
        check("reset_out_cos", bus.out_cos, 0);
        check("reset_out_sin", bus.out_sin, 0);
        check("reset_out_timeout", bus.out_timeout, 0);

        run_op(16'h0000, 16'h4000, 16'h0000, 3, 0, 0);
        run_op(16'h4000, 16'h4000, 16'h0000, 3, 0, 0);
        run_op(16'h9000, 16'h3B20, 16'h187E, 3, 0, 0);
        run_op(16'hB123, 16'h2ABC, 16'h1357, 0, 0, 1);
        run_op(16'h6789, 16'h1111, 16'h2222, 4, 0, 5);
        reset_mid_op(16'h7777);
        run_op(16'hC000, 16'h4000, 16'h0000, 1, 1, 0);
        run_op(16'hE001, 16'h8000, 16'h7FFF, TIMEOUT, 0, 0);
        run_op(16'h2468, 16'h0F0F, 16'hF0F0, TIMEOUT + 1, 1, 2);

        for (int i = 0; i < 30; i++) begin
            a = BW'($urandom);
            if (i % 5 == 0) a = {a[BW-1:BW-2], {(BW-2){1'b0}}};
            run_op(a, BW'($urandom), BW'($urandom), int'($urandom_range(1, 12)),
                   1'($urandom), int'($urandom_range(0, 3)));
        end

        repeat (5) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
